regfile_wb_arbiter: RTL

- Schedules writebacks into the single-write-port register file.
- Two writeback sources share that one port: ALU results and memory/load results.
- Each source gets a one-entry holding buffer with valid/ready handshake. Grants are round-robin, and the block drives the register file's rd / write_data / RegWrite from registered outputs.
- A pending-write scoreboard answers read-hazard queries for the decode stage.

---
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-source (ALU / load) writeback arbiter for the single-write-port register file, plus pending-write scoreboard.
// Latency: accept at edge N -> rf_regwrite high in cycle N+1; round-robin under contention.
// Backpressure: per-source one-entry buffer; ready = empty or being granted this cycle, forced low in reset.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    output logic            rf_regwrite,
    output logic [NREG-1:0] pending
);

    logic            alu_full, mem_full;
    logic [AW-1:0]   alu_buf_rd, mem_buf_rd;
    logic [XLEN-1:0] alu_buf_data, mem_buf_data;
    logic            ptr_mem;
    logic            grant_alu, grant_mem;
    logic            alu_take, mem_take;
    logic [NREG-1:0] pending_nxt;

    // ptr_mem=1 means the load source wins the next tie
    always_comb begin
        grant_alu = alu_full && (!mem_full || !ptr_mem);
        grant_mem = mem_full && (!alu_full || ptr_mem);
    end

    assign alu_ready = reset && (!alu_full || grant_alu);
    assign mem_ready = reset && (!mem_full || grant_mem);

    // rd=0 requests complete the handshake but never enter a buffer
    assign alu_take = alu_valid && alu_ready && (alu_rd != '0);
    assign mem_take = mem_valid && mem_ready && (mem_rd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_full     <= 1'b0;
            alu_buf_rd   <= '0;
            alu_buf_data <= '0;
            mem_full     <= 1'b0;
            mem_buf_rd   <= '0;
            mem_buf_data <= '0;
            ptr_mem      <= 1'b0;
        end else begin
            if (grant_alu) alu_full <= 1'b0;
            if (alu_take) begin
                alu_full     <= 1'b1;
                alu_buf_rd   <= alu_rd;
                alu_buf_data <= alu_data;
            end
            if (grant_mem) mem_full <= 1'b0;
            if (mem_take) begin
                mem_full     <= 1'b1;
                mem_buf_rd   <= mem_rd;
                mem_buf_data <= mem_data;
            end
            if (grant_alu)      ptr_mem <= 1'b1;
            else if (grant_mem) ptr_mem <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_regwrite   <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
        end else if (grant_alu) begin
            rf_regwrite   <= 1'b1;
            rf_rd         <= alu_buf_rd;
            rf_write_data <= alu_buf_data;
        end else if (grant_mem) begin
            rf_regwrite   <= 1'b1;
            rf_rd         <= mem_buf_rd;
            rf_write_data <= mem_buf_data;
        end else begin
            rf_regwrite   <= 1'b0;
        end
    end

    // Clear on the commit edge first so a same-edge re-issue leaves the bit set
    always_comb begin
        pending_nxt = pending;
        if (rf_regwrite) pending_nxt[rf_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign rs1_busy = (rs1 != '0) && pending[rs1];
    assign rs2_busy = (rs2 != '0) && pending[rs2];

endmodule
